soc_periph_req_arbiter: RTL and testbench
=========================================

// Module: soc_periph_req_arbiter
// PURPOSE
//  Shares the SoC peripheral address space between NrMasters requesters. Round-robin
//  arbitration; decodes each address against the soc_bus_start_t/Length map to a
//  one-hot target select. Exactly one transaction is in flight at a time.
//  Sits between the master-side request ports and the peripheral crossbar slave ports.
// PARAMETERS
//  NrMasters     2     number of requesting masters
//  NrTargets     12    number of map entries, indexed as axi_slaves_t (DRAM=0 .. LSM=11)
//  AddrWidth     64    request address width
//  DataWidth     64    data width; byte enable width is DataWidth/8
//  TimeoutCycles 1024  WAIT-state cycle limit (used only with PERIPH_ARB_TIMEOUT_EN)
// PORTS
//  clk_i          in   1                    clock
//  rst_i          in   1                    synchronous, active-high reset
//  m_req_valid_i  in   NrMasters            per-master request valid
//  m_req_ready_o  out  NrMasters            per-master request accept (one-hot pulse)
//  m_req_addr_i   in   NrMasters*AddrWidth  request address
//  m_req_we_i     in   NrMasters            write enable
//  m_req_wdata_i  in   NrMasters*DataWidth  write data
//  m_req_be_i     in   NrMasters*DataWidth/8 byte enables
//  m_rsp_valid_o  out  NrMasters            response valid, to the granted master only
//  m_rsp_ready_i  in   NrMasters            response accept
//  m_rsp_rdata_o  out  DataWidth            response read data (shared)
//  m_rsp_err_o    out  1                    response error (decode miss, target err, timeout)
//  t_req_valid_o  out  1                    target request valid
//  t_req_ready_i  in   1                    target request accept
//  t_req_sel_o    out  NrTargets            one-hot target select
//  t_req_addr_o / t_req_we_o / t_req_wdata_o / t_req_be_o  out  as master  registered request
//  t_rsp_valid_i  in   1                    target response strobe (no back-pressure)
//  t_rsp_rdata_i  in   DataWidth            target read data
//  t_rsp_err_i    in   1                    target error
//  busy_o         out  1                    state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. RR pointer = NrMasters-1, so master 0 is served first.
//  Reset mid-transaction abandons the transaction; a later t_rsp_valid_i is ignored.
//  IDLE:  the first requester after the RR pointer wins. m_req_ready_o[win]=1 in the
//         same cycle (ready may depend on valid; valid never depends on ready).
//         The cycle registers grant, addr, we, wdata, be and the decode result.
//         Decode hit -> ISSUE. Decode miss -> RSP with err=1, rdata=0.
//  ISSUE: t_req_valid_o=1 with stable fields until t_req_ready_i, then -> WAIT.
//  WAIT:  t_rsp_valid_i captures rdata and err -> RSP. t_rsp_valid_i is ignored in
//         every other state.
//  RSP:   m_rsp_valid_o[grant]=1 until m_rsp_ready_i[grant]. Then -> IDLE and RR pointer = grant.
//         New requests are accepted only in IDLE, so there is at least one bubble cycle.
//  Decode: target i hits when Base_i <= addr < Base_i+Length_i, using 64-bit unsigned
//         arithmetic with no wrap. On overlap the lowest index wins.
//  Latency: hit with a ready target and a 1-cycle target response gives m_rsp_valid_o
//         3 cycles after acceptance. A decode miss gives it 1 cycle after acceptance.
// CONFIGURATION
//  PERIPH_ARB_TIMEOUT_EN defined: a counter clears on entry to WAIT. When it reaches
//  TimeoutCycles without t_rsp_valid_i, the block goes to RSP with err=1, rdata=0.
//  A late target response is ignored. ISSUE is never timed out, so a request is never withdrawn.
//  Macro undefined: no counter; WAIT waits indefinitely.
// STRUCTURE
//  Package soc_periph_arb_pkg: state_e {IDLE, ISSUE, WAIT, RSP}; addr_rule_t {base, length};
//  localparam rule table built from soc_bus_start_t and *Length; target index = axi_slaves_t.
//  Sub-module soc_addr_decode: combinational address -> {hit, one-hot sel}.
// TESTING
//  1 Master 0 reads 0x1000_0000 (UART), target ready, rsp 0xAB next cycle
//    -> t_req_sel_o[5]=1; m_rsp_rdata_o=0xAB, err=0, 3 cycles after accept.
//  2 Both masters request continuously, 4 transactions -> grants alternate 0,1,0,1.
//  3 Address 0x5000_0000 (unmapped) -> no t_req_valid_o; m_rsp_err_o=1 one cycle after accept.
//  4 Address 0x180_0000_0000 with t_req_ready_i low 5 cycles
//    -> t_req_sel_o[0]=1 and fields stable throughout; one target request issued.
//  5 rst_i in WAIT, then t_rsp_valid_i -> outputs 0, IDLE, response dropped.
//  6 (PERIPH_ARB_TIMEOUT_EN, TimeoutCycles=8) target never responds
//    -> err=1 after 8 WAIT cycles; a later t_rsp_valid_i is ignored.

Source files
------------

// File: rtl/soc_periph_arb_pkg.sv
// Shared types and the peripheral address map for the peripheral request arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package soc_periph_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RSP
   } state_e;

   typedef struct packed {
      logic [63:0] base;
      logic [63:0] length;
   } addr_rule_t;

   // Map-entry index of each peripheral; this is also the bit position in the one-hot select.
   typedef enum logic [3:0] {
      DRAM     = 4'd0,
      GPIO     = 4'd1,
      Ethernet = 4'd2,
      SPI      = 4'd3,
      Timer    = 4'd4,
      UART     = 4'd5,
      PLIC     = 4'd6,
      CLINT    = 4'd7,
      ROM      = 4'd8,
      Debug    = 4'd9,
      SRAM     = 4'd10,
      LSM      = 4'd11
   } axi_slaves_t;

   localparam int unsigned NrMapEntries = 12;

   typedef enum logic [63:0] {
      DebugBase    = 64'h0000_0000,
      ROMBase      = 64'h0001_0000,
      CLINTBase    = 64'h0200_0000,
      SRAMBase     = 64'h0800_0000,
      PLICBase     = 64'h0C00_0000,
      UARTBase     = 64'h1000_0000,
      TimerBase    = 64'h1800_0000,
      SPIBase      = 64'h2000_0000,
      EthernetBase = 64'h3000_0000,
      GPIOBase     = 64'h4000_0000,
      LSMBase      = 64'h7000_0000,
      DRAMBase     = 64'h180_0000_0000
   } soc_bus_start_t;

   localparam logic [63:0] DebugLength    = 64'h1000;
   localparam logic [63:0] ROMLength      = 64'h1_0000;
   localparam logic [63:0] CLINTLength    = 64'hC_0000;
   localparam logic [63:0] SRAMLength     = 64'h2_0000;
   localparam logic [63:0] PLICLength     = 64'h400_0000;
   localparam logic [63:0] UARTLength     = 64'h1000;
   localparam logic [63:0] TimerLength    = 64'h1000;
   localparam logic [63:0] SPILength      = 64'h80_0000;
   localparam logic [63:0] EthernetLength = 64'h1_0000;
   localparam logic [63:0] GPIOLength     = 64'h1000;
   localparam logic [63:0] LSMLength      = 64'h1000_0000;
   localparam logic [63:0] DRAMLength     = 64'h4000_0000;

   // Entry order follows axi_slaves_t (DRAM first, LSM last).
   localparam addr_rule_t AddrMap [NrMapEntries] = '{
      '{base: DRAMBase,     length: DRAMLength},
      '{base: GPIOBase,     length: GPIOLength},
      '{base: EthernetBase, length: EthernetLength},
      '{base: SPIBase,      length: SPILength},
      '{base: TimerBase,    length: TimerLength},
      '{base: UARTBase,     length: UARTLength},
      '{base: PLICBase,     length: PLICLength},
      '{base: CLINTBase,    length: CLINTLength},
      '{base: ROMBase,      length: ROMLength},
      '{base: DebugBase,    length: DebugLength},
      '{base: SRAMBase,     length: SRAMLength},
      '{base: LSMBase,      length: LSMLength}
   };

   // Window check done in 65 bits so base+length never wraps past 2^64.
   function automatic logic rule_hit(input addr_rule_t rule, input logic [63:0] addr);
      logic [64:0] limit;
      limit = {1'b0, rule.base} + {1'b0, rule.length};
      return (addr >= rule.base) && ({1'b0, addr} < limit);
   endfunction

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational address decoder: address -> {hit, one-hot select} over the peripheral map.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every cycle.
module soc_addr_decode
   import soc_periph_arb_pkg::*;
#(
   parameter int unsigned NrTargets = 12,
   parameter int unsigned AddrWidth = 64
) (
   input  logic [AddrWidth-1:0] addr_i,
   output logic                 hit_o,
   output logic [NrTargets-1:0] sel_o
);

   localparam int unsigned NrRules = (NrTargets < NrMapEntries) ? NrTargets : NrMapEntries;

   logic [63:0] addr64;

   assign addr64 = 64'(addr_i);

   // Scan from the highest index down so the lowest matching entry is the one left standing.
   always_comb begin
      hit_o = 1'b0;
      sel_o = '0;
      for (int i = int'(NrRules) - 1; i >= 0; i--) begin
         if (rule_hit(AddrMap[i], addr64)) begin
            sel_o    = '0;
            sel_o[i] = 1'b1;
            hit_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/soc_periph_req_arbiter.sv
// Round-robin arbiter sharing the peripheral space among masters; one transaction in flight.
// Latency: accept->rsp 3 cycles for a hit with ready target and 1-cycle response; 1 cycle on decode miss.
// Backpressure: requests accepted only in IDLE; ISSUE holds until target ready; RSP holds until master ready.
// Optional PERIPH_ARB_TIMEOUT_EN: WAIT gives up after TimeoutCycles and answers with an error.
module soc_periph_req_arbiter
   import soc_periph_arb_pkg::*;
#(
   parameter int unsigned NrMasters     = 2,
   parameter int unsigned NrTargets     = 12,
   parameter int unsigned AddrWidth     = 64,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NrMasters-1:0]             m_req_valid_i,
   output logic [NrMasters-1:0]             m_req_ready_o,
   input  logic [NrMasters*AddrWidth-1:0]   m_req_addr_i,
   input  logic [NrMasters-1:0]             m_req_we_i,
   input  logic [NrMasters*DataWidth-1:0]   m_req_wdata_i,
   input  logic [NrMasters*DataWidth/8-1:0] m_req_be_i,
   output logic [NrMasters-1:0]             m_rsp_valid_o,
   input  logic [NrMasters-1:0]             m_rsp_ready_i,
   output logic [DataWidth-1:0]             m_rsp_rdata_o,
   output logic                             m_rsp_err_o,
   output logic                             t_req_valid_o,
   input  logic                             t_req_ready_i,
   output logic [NrTargets-1:0]             t_req_sel_o,
   output logic [AddrWidth-1:0]             t_req_addr_o,
   output logic                             t_req_we_o,
   output logic [DataWidth-1:0]             t_req_wdata_o,
   output logic [DataWidth/8-1:0]           t_req_be_o,
   input  logic                             t_rsp_valid_i,
   input  logic [DataWidth-1:0]             t_rsp_rdata_i,
   input  logic                             t_rsp_err_i,
   output logic                             busy_o
);

   localparam int unsigned GrantW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
   localparam int unsigned BeW    = DataWidth / 8;

   // Elaboration-time sanity on the configuration.
   if (NrMasters < 1 || TimeoutCycles < 1 || (DataWidth % 8) != 0) begin : g_param_check
      $error("soc_periph_req_arbiter: illegal parameter combination");
   end

   state_e              state_q, state_d;
   logic [GrantW-1:0]   rr_q, rr_d;
   logic [GrantW-1:0]   grant_q, grant_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                we_q, we_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [BeW-1:0]      be_q, be_d;
   logic [NrTargets-1:0] sel_q, sel_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                err_q, err_d;

`ifdef PERIPH_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0]     cnt_q, cnt_d;
`endif

   logic                win_vld;
   logic [GrantW-1:0]   win_idx;
   logic [AddrWidth-1:0] win_addr;
   logic                dec_hit;
   logic [NrTargets-1:0] dec_sel;

   // Pick the first valid requester after the round-robin pointer, wrapping around.
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 1; k <= int'(NrMasters); k++) begin
         idx = (int'(rr_q) + k) % int'(NrMasters);
         if (!win_vld && m_req_valid_i[idx]) begin
            win_vld = 1'b1;
            win_idx = GrantW'(idx);
         end
      end
   end

   assign win_addr = m_req_addr_i[int'(win_idx)*AddrWidth +: AddrWidth];

   soc_addr_decode #(
      .NrTargets (NrTargets),
      .AddrWidth (AddrWidth)
   ) u_decode (
      .addr_i (win_addr),
      .hit_o  (dec_hit),
      .sel_o  (dec_sel)
   );

   // Next-state and handshake outputs; all handshakes are forced low while reset is held.
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      grant_d       = grant_q;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      sel_d         = sel_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
`ifdef PERIPH_ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      m_req_ready_o = '0;
      m_rsp_valid_o = '0;
      t_req_valid_o = 1'b0;

      case (state_q)
         IDLE: begin
            if (win_vld) begin
               m_req_ready_o[win_idx] = 1'b1;
               grant_d = win_idx;
               addr_d  = win_addr;
               we_d    = m_req_we_i[win_idx];
               wdata_d = m_req_wdata_i[int'(win_idx)*DataWidth +: DataWidth];
               be_d    = m_req_be_i[int'(win_idx)*BeW +: BeW];
               sel_d   = dec_sel;
               rdata_d = '0;
               err_d   = !dec_hit;
               state_d = dec_hit ? ISSUE : RSP;
            end
         end
         ISSUE: begin
            t_req_valid_o = 1'b1;
            if (t_req_ready_i) begin
               state_d = WAIT;
`ifdef PERIPH_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT: begin
            if (t_rsp_valid_i) begin
               rdata_d = t_rsp_rdata_i;
               err_d   = t_rsp_err_i;
               state_d = RSP;
            end
`ifdef PERIPH_ARB_TIMEOUT_EN
            else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RSP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RSP: begin
            m_rsp_valid_o[grant_q] = 1'b1;
            if (m_rsp_ready_i[grant_q]) begin
               state_d = IDLE;
               rr_d    = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst_i) begin
         m_req_ready_o = '0;
         m_rsp_valid_o = '0;
         t_req_valid_o = 1'b0;
      end
   end

   // State and captured-transaction registers; reset abandons any open transaction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rr_q    <= GrantW'(NrMasters - 1);
         grant_q <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef PERIPH_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign t_req_sel_o   = sel_q;
   assign t_req_addr_o  = addr_q;
   assign t_req_we_o    = we_q;
   assign t_req_wdata_o = wdata_q;
   assign t_req_be_o    = be_q;
   assign m_rsp_rdata_o = rdata_q;
   assign m_rsp_err_o   = err_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_soc_periph_req_arbiter.sv
// Self-checking bench for soc_periph_req_arbiter: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: bench acts as both masters and the target, with randomized ready/response delays.
module tb_soc_periph_req_arbiter;

   localparam int NM = 2;
   localparam int NT = 12;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NM-1:0]     m_req_valid_i;
   logic [NM-1:0]     m_req_ready_o;
   logic [NM*AW-1:0]  m_req_addr_i;
   logic [NM-1:0]     m_req_we_i;
   logic [NM*DW-1:0]  m_req_wdata_i;
   logic [NM*BW-1:0]  m_req_be_i;
   logic [NM-1:0]     m_rsp_valid_o;
   logic [NM-1:0]     m_rsp_ready_i;
   logic [DW-1:0]     m_rsp_rdata_o;
   logic              m_rsp_err_o;
   logic              t_req_valid_o;
   logic              t_req_ready_i;
   logic [NT-1:0]     t_req_sel_o;
   logic [AW-1:0]     t_req_addr_o;
   logic              t_req_we_o;
   logic [DW-1:0]     t_req_wdata_o;
   logic [BW-1:0]     t_req_be_o;
   logic              t_rsp_valid_i;
   logic [DW-1:0]     t_rsp_rdata_i;
   logic              t_rsp_err_i;
   logic              busy_o;

   always #5 clk = ~clk;

   soc_periph_req_arbiter #(
      .NrMasters     (NM),
      .NrTargets     (NT),
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .TimeoutCycles (8)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .m_req_valid_i (m_req_valid_i),
      .m_req_ready_o (m_req_ready_o),
      .m_req_addr_i  (m_req_addr_i),
      .m_req_we_i    (m_req_we_i),
      .m_req_wdata_i (m_req_wdata_i),
      .m_req_be_i    (m_req_be_i),
      .m_rsp_valid_o (m_rsp_valid_o),
      .m_rsp_ready_i (m_rsp_ready_i),
      .m_rsp_rdata_o (m_rsp_rdata_o),
      .m_rsp_err_o   (m_rsp_err_o),
      .t_req_valid_o (t_req_valid_o),
      .t_req_ready_i (t_req_ready_i),
      .t_req_sel_o   (t_req_sel_o),
      .t_req_addr_o  (t_req_addr_o),
      .t_req_we_o    (t_req_we_o),
      .t_req_wdata_o (t_req_wdata_o),
      .t_req_be_o    (t_req_be_o),
      .t_rsp_valid_i (t_rsp_valid_i),
      .t_rsp_rdata_i (t_rsp_rdata_i),
      .t_rsp_err_i   (t_rsp_err_i),
      .busy_o        (busy_o)
   );

   // Reference memory map, listed by target index (DRAM .. LSM).
   logic [63:0] tb_base [NT] = '{
      64'h180_0000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000,
      64'h1800_0000,     64'h1000_0000, 64'h0C00_0000, 64'h0200_0000,
      64'h0001_0000,     64'h0000_0000, 64'h0800_0000, 64'h7000_0000
   };
   logic [63:0] tb_len [NT] = '{
      64'h4000_0000, 64'h1000,     64'h1_0000, 64'h80_0000,
      64'h1000,      64'h1000,     64'h400_0000, 64'hC_0000,
      64'h1_0000,    64'h1000,     64'h2_0000, 64'h1000_0000
   };

   int checks = 0;
   int errors = 0;
   int model_rr;
   int n_issued = 0;

   // Count target-side handshakes so a request issued twice is visible.
   always @(posedge clk) begin
      if (t_req_valid_o && t_req_ready_i) n_issued <= n_issued + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Lowest-index entry whose window [base, base+len) contains the address; -1 if none.
   function automatic int model_decode(input logic [63:0] a);
      for (int i = 0; i < NT; i++) begin
         if (a >= tb_base[i] && (a - tb_base[i]) < tb_len[i]) return i;
      end
      return -1;
   endfunction

   // Master after the last-served one, wrapping; -1 if nobody requests.
   function automatic int model_winner(input logic [NM-1:0] vld);
      for (int k = 1; k <= NM; k++) begin
         if (vld[(model_rr + k) % NM]) return (model_rr + k) % NM;
      end
      return -1;
   endfunction

   function automatic logic [63:0] rand_addr();
      int i;
      i = $urandom_range(0, NT - 1);
      case ($urandom_range(0, 4))
         0: return tb_base[i] + ({$urandom, $urandom} % tb_len[i]);
         1: return tb_base[i] + tb_len[i] - 64'd1;
         2: return tb_base[i] + tb_len[i];
         3: return tb_base[i] - 64'd1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // One full transaction, starting at a negedge with the DUT idle.
   task automatic txn(input logic [NM-1:0] vld, input logic [63:0] a0, input logic [63:0] a1,
                      input int trdy_dly, input int rsp_dly, input int mrdy_dly,
                      input logic [63:0] rd_in, input logic terr_in);
      int          w, tgt, iss0;
      logic [63:0] wd [NM];
      logic [7:0]  be [NM];
      logic [NM-1:0] we, oh;
      logic [63:0] exp_rd, addr_w;
      logic        exp_err;
      w = model_winner(vld);
      oh = NM'(1) << w;
      for (int m = 0; m < NM; m++) begin
         wd[m] = {$urandom, $urandom};
         be[m] = 8'($urandom);
         we[m] = 1'($urandom);
      end
      m_req_valid_i = vld;
      m_req_addr_i  = {a1, a0};
      m_req_we_i    = we;
      m_req_wdata_i = {wd[1], wd[0]};
      m_req_be_i    = {be[1], be[0]};
      addr_w        = (w == 1) ? a1 : a0;
      tgt           = model_decode(addr_w);
      iss0          = n_issued;
      #1;
      chk("req_ready", 128'(m_req_ready_o), 128'(oh));
      chk("idle_busy", 128'(busy_o), 128'(0));
      @(negedge clk);
      m_req_valid_i = '0;
      if (tgt >= 0) begin
         for (int d = 0; d <= trdy_dly; d++) begin
            t_req_ready_i = (d == trdy_dly);
            #1;
            chk("t_req_valid", 128'(t_req_valid_o), 128'(1));
            chk("t_req_sel", 128'(t_req_sel_o), 128'(NT'(1) << tgt));
            chk("t_req_addr", 128'(t_req_addr_o), 128'(addr_w));
            chk("t_req_we", 128'(t_req_we_o), 128'(we[w]));
            chk("t_req_wdata", 128'(t_req_wdata_o), 128'(wd[w]));
            chk("t_req_be", 128'(t_req_be_o), 128'(be[w]));
            chk("rsp_early", 128'(m_rsp_valid_o), 128'(0));
            @(negedge clk);
         end
         t_req_ready_i = 1'b0;
         for (int d = 0; d <= rsp_dly; d++) begin
            t_rsp_valid_i = (d == rsp_dly);
            t_rsp_rdata_i = rd_in;
            t_rsp_err_i   = terr_in;
            #1;
            chk("wait_no_treq", 128'(t_req_valid_o), 128'(0));
            chk("wait_no_rsp", 128'(m_rsp_valid_o), 128'(0));
            chk("wait_busy", 128'(busy_o), 128'(1));
            @(negedge clk);
         end
         t_rsp_valid_i = 1'b0;
         t_rsp_rdata_i = {$urandom, $urandom};
         t_rsp_err_i   = 1'b0;
         exp_rd  = rd_in;
         exp_err = terr_in;
      end else begin
         exp_rd  = 64'd0;
         exp_err = 1'b1;
      end
      for (int d = 0; d <= mrdy_dly; d++) begin
         m_rsp_ready_i = (d == mrdy_dly) ? oh : ~oh;
         #1;
         chk("rsp_valid", 128'(m_rsp_valid_o), 128'(oh));
         chk("rsp_rdata", 128'(m_rsp_rdata_o), 128'(exp_rd));
         chk("rsp_err", 128'(m_rsp_err_o), 128'(exp_err));
         chk("rsp_no_treq", 128'(t_req_valid_o), 128'(0));
         @(negedge clk);
      end
      m_rsp_ready_i = '0;
      model_rr = w;
      #1;
      chk("bubble_idle", 128'(busy_o), 128'(0));
      chk("bubble_no_rsp", 128'(m_rsp_valid_o), 128'(0));
      chk("issue_count", 128'(n_issued - iss0), 128'((tgt >= 0) ? 1 : 0));
   endtask

   initial begin
      int w;
      rst = 1'b1;
      m_req_valid_i = '0; m_req_addr_i = '0; m_req_we_i = '0;
      m_req_wdata_i = '0; m_req_be_i = '0; m_rsp_ready_i = '0;
      t_req_ready_i = 1'b0; t_rsp_valid_i = 1'b0; t_rsp_rdata_i = '0; t_rsp_err_i = 1'b0;
      model_rr = NM - 1;
      repeat (3) @(negedge clk);

      // Reset state, with a request pending that must not be accepted during reset.
      m_req_valid_i = 2'b11;
      #1;
      chk("rst_req_ready", 128'(m_req_ready_o), 128'(0));
      chk("rst_busy", 128'(busy_o), 128'(0));
      chk("rst_t_req_valid", 128'(t_req_valid_o), 128'(0));
      chk("rst_rsp_valid", 128'(m_rsp_valid_o), 128'(0));
      chk("rst_sel", 128'(t_req_sel_o), 128'(0));
      chk("rst_rdata", 128'(m_rsp_rdata_o), 128'(0));
      m_req_valid_i = '0;
      @(negedge clk);
      rst = 1'b0;

      // UART read, ready target, response next cycle.
      txn(2'b01, 64'h1000_0000, 64'h0, 0, 0, 0, 64'hAB, 1'b0);

      // Both masters requesting: grants must alternate.
      for (int i = 0; i < 4; i++) txn(2'b11, 64'h1000_0010, 64'h4000_0020, 0, 0, 0, {$urandom, $urandom}, 1'b0);

      // Unmapped address.
      txn(2'b11, 64'h5000_0000, 64'h5000_0000, 0, 0, 0, 64'h0, 1'b0);

      // DRAM with a stalled target for 5 cycles.
      txn(2'b01, 64'h180_0000_0000, 64'h180_0000_0000, 5, 0, 0, 64'h1234_5678_9ABC_DEF0, 1'b0);
      txn(2'b10, 64'h0, 64'h180_0000_0000, 5, 2, 1, 64'hFEED, 1'b1);

      // Reset while waiting on the target; the late response must be dropped.
      m_req_valid_i = 2'b11;
      m_req_addr_i  = {64'h1000_0000, 64'h1000_0000};
      @(negedge clk);
      m_req_valid_i = '0;
      t_req_ready_i = 1'b1;
      @(negedge clk);
      t_req_ready_i = 1'b0;
      #1;
      chk("pre_rst_busy", 128'(busy_o), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t_rsp_valid_i = 1'b1;
      t_rsp_rdata_i = 64'hDEAD;
      t_rsp_err_i   = 1'b1;
      #1;
      chk("midrst_busy", 128'(busy_o), 128'(0));
      chk("midrst_rsp_valid", 128'(m_rsp_valid_o), 128'(0));
      chk("midrst_sel", 128'(t_req_sel_o), 128'(0));
      chk("midrst_addr", 128'(t_req_addr_o), 128'(0));
      chk("midrst_rdata", 128'(m_rsp_rdata_o), 128'(0));
      chk("midrst_err", 128'(m_rsp_err_o), 128'(0));
      @(negedge clk);
      t_rsp_valid_i = 1'b0;
      #1;
      chk("dropped_rsp_valid", 128'(m_rsp_valid_o), 128'(0));
      chk("dropped_busy", 128'(busy_o), 128'(0));
      model_rr = NM - 1;
      @(negedge clk);
      txn(2'b11, 64'h2000_0000, 64'h3000_0000, 1, 1, 0, {$urandom, $urandom}, 1'b0);

`ifdef PERIPH_ARB_TIMEOUT_EN
      // Target never answers: error after 8 WAIT cycles, late response ignored.
      w = model_winner(2'b11);
      m_req_valid_i = 2'b11;
      m_req_addr_i  = {64'h1800_0000, 64'h1800_0000};
      @(negedge clk);
      m_req_valid_i = '0;
      t_req_ready_i = 1'b1;
      @(negedge clk);
      t_req_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("to_wait_no_rsp", 128'(m_rsp_valid_o), 128'(0));
         @(negedge clk);
      end
      #1;
      chk("to_rsp_valid", 128'(m_rsp_valid_o), 128'(NM'(1) << w));
      chk("to_rsp_err", 128'(m_rsp_err_o), 128'(1));
      chk("to_rsp_rdata", 128'(m_rsp_rdata_o), 128'(0));
      @(negedge clk);
      t_rsp_valid_i = 1'b1;
      t_rsp_rdata_i = 64'h5555;
      t_rsp_err_i   = 1'b0;
      @(negedge clk);
      t_rsp_valid_i = 1'b0;
      #1;
      chk("to_late_err", 128'(m_rsp_err_o), 128'(1));
      chk("to_late_rdata", 128'(m_rsp_rdata_o), 128'(0));
      m_rsp_ready_i = NM'(1) << w;
      @(negedge clk);
      m_rsp_ready_i = '0;
      model_rr = w;
      #1;
      chk("to_idle", 128'(busy_o), 128'(0));
`else
      w = 0;
`endif

      // Randomized traffic across the map, its edges and random addresses.
      for (int i = 0; i < 40; i++) begin
         logic [NM-1:0] v;
         v = NM'($urandom_range(1, 3));
         txn(v, rand_addr(), rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), {$urandom, $urandom}, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
